// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

    // Register-specifier width of the rs/rt fields.
    localparam int unsigned REG_W = 5;

    // Default number of EX-stage cycles for a multi-cycle multiply.
    localparam int unsigned MUL_LAT_DEF = 4;

    typedef enum logic [0:0] {
        StRun,
        StMulWait
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use hazard detector: the load in EX writes a register that
// the instruction in ID reads. Register 0 never carries a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    output logic             load_use_o
);

    // Flag a dependency only for a load with a real (non-zero) destination.
    always_comb begin
        load_use_o = ex_mem_read_i && (ex_rt_i != '0) &&
                     ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller for a 5-stage pipe with a multi-cycle multiply.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             branch_taken,
    input  logic             mul_start,
    input  logic             mem_wait,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]      stall_cycles,
    output logic [31:0]      flush_events,
`endif
    output logic             busy
);

    // The start cycle is itself a freeze cycle, so the counter covers the remaining
    // MUL_LAT-2 freeze cycles before the release cycle.
    localparam logic [3:0] MulCntInit = 4'(MUL_LAT - 2);

    state_e     state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    logic       load_use;

    hazard_detect u_hazard_detect (
        .ex_mem_read_i (ex_mem_read),
        .ex_rt_i       (ex_rt),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .load_use_o    (load_use)
    );

    // State and multiply counter register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StRun;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Next-state and Mealy outputs, in priority order.
    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;

        if (!reset || mem_wait) begin
            // Whole-pipe freeze; state and counter hold.
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            memwb_en = 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (branch_taken) begin
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                    end else if (mul_start) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        state_d     = StMulWait;
                        mul_cnt_d   = MulCntInit;
                    end else if (load_use) begin
                        pc_en      = 1'b0;
                        ifid_en    = 1'b0;
                        idex_flush = 1'b1;
                    end
                end
                StMulWait: begin
                    if (mul_cnt_q != 4'd0) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idex_en     = 1'b0;
                        exmem_flush = 1'b1;
                        mul_cnt_d   = mul_cnt_q - 4'd1;
                    end else begin
                        // Multiply result advances into EX/MEM this cycle.
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // Busy flag follows the state register directly.
    always_comb begin
        busy = (state_q == StMulWait);
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_events_q, flush_events_d;

    // Counter next values; both wrap naturally at 2^32.
    always_comb begin
        stall_cycles_d = stall_cycles_q + {31'd0, ~pc_en};
        flush_events_d = flush_events_q + {31'd0, (ifid_flush | idex_flush | exmem_flush)};
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with MUL_LAT=4.
module tb_pipe_ctrl;

    logic       clk;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_mem_read, branch_taken, mul_start, mem_wait;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles, flush_events;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Output vector: {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes, busy}
    logic [8:0] outs;
    assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                   ifid_flush, idex_flush, exmem_flush, busy};

    localparam logic [8:0] O_RST   = 9'b00000_000_0;
    localparam logic [8:0] O_DEF   = 9'b11111_000_0;
    localparam logic [8:0] O_LU    = 9'b00111_010_0;
    localparam logic [8:0] O_BR    = 9'b11111_110_0;
    localparam logic [8:0] O_MULF  = 9'b00011_001_0;
    localparam logic [8:0] O_MULB  = 9'b00011_001_1;
    localparam logic [8:0] O_MULR  = 9'b11111_000_1;
    localparam logic [8:0] O_MWRUN = 9'b00000_000_0;
    localparam logic [8:0] O_MWMUL = 9'b00000_000_1;

    pipe_ctrl #(
        .MUL_LAT (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .branch_taken (branch_taken),
        .mul_start    (mul_start),
        .mem_wait     (mem_wait),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
        .exmem_flush  (exmem_flush),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cycles (stall_cycles),
        .flush_events (flush_events),
`endif
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        ex_mem_read = 1'b0; branch_taken = 1'b0; mul_start = 1'b0; mem_wait = 1'b0;
    endtask

    // Check outputs mid-cycle with current inputs, then advance one cycle.
    task automatic cyc(input string tag, input logic [8:0] exp);
        @(negedge clk);
        check_eq(tag, {23'd0, outs}, {23'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        @(negedge clk);
        check_eq("reset_outs", {23'd0, outs}, {23'd0, O_RST});
`ifdef PIPE_CTRL_PERF_EN
        check_eq("reset_stall_cnt", stall_cycles, 32'd0);
        check_eq("reset_flush_cnt", flush_events, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc("run_default", O_DEF);

        // Load-use on rs: exactly one stall, then the load has left EX.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc("lu_rs", O_LU);
        idle_inputs();
        cyc("lu_rs_after", O_DEF);

        // Load-use on rt.
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3;
        cyc("lu_rt", O_LU);
        idle_inputs();

        // Register 0 never hazards; no hazard without a load.
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cyc("lu_r0", O_DEF);
        ex_mem_read = 1'b0; ex_rt = 5'd7; id_rs = 5'd7;
        cyc("no_load", O_DEF);
        idle_inputs();

        // Branch beats load-use.
        branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
        cyc("br_over_lu", O_BR);
        idle_inputs();

        // mem_wait in RUN overrides mul_start; state must stay RUN.
        mem_wait = 1'b1; mul_start = 1'b1;
        cyc("memwait_run", O_MWRUN);
        idle_inputs();
        cyc("memwait_run_after", O_DEF);

        // Multiply: 3 freeze cycles then release; branch/mul_start ignored in MUL_WAIT.
        mul_start = 1'b1;
        cyc("mul_c1", O_MULF);
        branch_taken = 1'b1;
        cyc("mul_c2", O_MULB);
        idle_inputs();
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cyc("mul_c3", O_MULB);
        idle_inputs();
        cyc("mul_release", O_MULR);
        cyc("mul_done", O_DEF);

        // mem_wait during MUL_WAIT extends the freeze by 2 cycles.
        mul_start = 1'b1;
        cyc("mw_c1", O_MULF);
        mul_start = 1'b0;
        cyc("mw_c2", O_MULB);
        mem_wait = 1'b1;
        cyc("mw_hold1", O_MWMUL);
        cyc("mw_hold2", O_MWMUL);
        mem_wait = 1'b0;
        cyc("mw_c3", O_MULB);
        cyc("mw_release", O_MULR);
        cyc("mw_done", O_DEF);

        // Reset in MUL_WAIT aborts immediately.
        mul_start = 1'b1;
        cyc("rp_c1", O_MULF);
        mul_start = 1'b0;
        cyc("rp_c2", O_MULB);
        reset = 1'b0;
        #1;
        check_eq("rp_busy_now", {31'd0, busy}, 32'd0);
        check_eq("rp_outs_now", {23'd0, outs}, {23'd0, O_RST});
        cyc("rp_held", O_RST);
        reset = 1'b1;
`ifdef PIPE_CTRL_PERF_EN
        @(negedge clk);
        check_eq("rp_stall_cnt", stall_cycles, 32'd0);
        check_eq("rp_flush_cnt", flush_events, 32'd0);
`endif
        cyc("rp_run1", O_DEF);
        cyc("rp_run2", O_DEF);

`ifdef PIPE_CTRL_PERF_EN
        // Counted: load-use (stall 1, flush 1), branch (flush 1), mem_wait (stall 1),
        // multiply (stall 3, flush 3) -> stall 5, flush 5.
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cyc("pc_lu", O_LU);
        idle_inputs();
        branch_taken = 1'b1;
        cyc("pc_br", O_BR);
        idle_inputs();
        mem_wait = 1'b1;
        cyc("pc_mw", O_MWRUN);
        idle_inputs();
        mul_start = 1'b1;
        cyc("pc_m1", O_MULF);
        mul_start = 1'b0;
        cyc("pc_m2", O_MULB);
        cyc("pc_m3", O_MULB);
        cyc("pc_mr", O_MULR);
        @(negedge clk);
        check_eq("perf_stall_cnt", stall_cycles, 32'd5);
        check_eq("perf_flush_cnt", flush_events, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
